// File: rtl/mem_req_arbiter.sv
// Shared instruction/data memory port arbiter.
// Round-robin between the fetch unit and the MMU, one memory transaction at a
// time, with a watchdog that forces an error completion on a hung access.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; sample requests and pick a winner
// ISSUE | mem_req held high, waiting for mem_ready or watchdog expiry
// RESP  | owner's data_valid pulse (with bus_err); return to IDLE
module mem_req_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_grant,
   output logic                  if_data_valid,
   input  logic                  dmem_req_valid,
   input  logic                  dmem_we,
   input  logic [ADDR_WIDTH-1:0] dmem_addr,
   input  logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic                  dmem_grant,
   output logic                  dmem_data_valid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  bus_err,
   output logic                  arb_busy,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Counter value at the end of the last ISSUE cycle allowed to wait.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  last_fetch_q, last_fetch_d;   // 1: fetch owned the last transaction
   logic                  owner_fetch_q, owner_fetch_d; // 1: fetch owns the current transaction
   logic                  if_grant_q, if_grant_d;
   logic                  dmem_grant_q, dmem_grant_d;
   logic                  if_dv_q, if_dv_d;
   logic                  dmem_dv_q, dmem_dv_d;
   logic                  bus_err_q, bus_err_d;
   logic                  arb_busy_q, arb_busy_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  pick_dmem;

   // Next-state and next-output logic; every output is produced from a register.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      last_fetch_d  = last_fetch_q;
      owner_fetch_d = owner_fetch_q;
      if_grant_d    = 1'b0;
      dmem_grant_d  = 1'b0;
      if_dv_d       = 1'b0;
      dmem_dv_d     = 1'b0;
      bus_err_d     = 1'b0;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      rdata_d       = rdata_q;
      // MMU wins when alone, or on a tie when fetch had the previous turn.
      pick_dmem     = dmem_req_valid && (!if_req_valid || last_fetch_q);

      case (state_q)
         S_IDLE: begin
            if (if_req_valid || dmem_req_valid) begin
               owner_fetch_d = !pick_dmem;
               mem_req_d     = 1'b1;
               mem_we_d      = pick_dmem && dmem_we;
               mem_addr_d    = pick_dmem ? dmem_addr : if_addr;
               mem_wdata_d   = pick_dmem ? dmem_wdata : '0;
               dmem_grant_d  = pick_dmem;
               if_grant_d    = !pick_dmem;
               cnt_d         = '0;
               state_d       = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
            // A real completion wins over a watchdog expiry in the same cycle.
            if (mem_ready) begin
               mem_req_d = 1'b0;
               rdata_d   = mem_we_q ? '0 : mem_rdata;
               if_dv_d   = owner_fetch_q;
               dmem_dv_d = !owner_fetch_q;
               state_d   = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               rdata_d   = '0;
               bus_err_d = 1'b1;
               if_dv_d   = owner_fetch_q;
               dmem_dv_d = !owner_fetch_q;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            last_fetch_d = owner_fetch_q;
            cnt_d        = '0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      arb_busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         last_fetch_q  <= 1'b1;
         owner_fetch_q <= 1'b0;
         if_grant_q    <= 1'b0;
         dmem_grant_q  <= 1'b0;
         if_dv_q       <= 1'b0;
         dmem_dv_q     <= 1'b0;
         bus_err_q     <= 1'b0;
         arb_busy_q    <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         rdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_fetch_q  <= last_fetch_d;
         owner_fetch_q <= owner_fetch_d;
         if_grant_q    <= if_grant_d;
         dmem_grant_q  <= dmem_grant_d;
         if_dv_q       <= if_dv_d;
         dmem_dv_q     <= dmem_dv_d;
         bus_err_q     <= bus_err_d;
         arb_busy_q    <= arb_busy_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         rdata_q       <= rdata_d;
      end
   end

   assign if_grant        = if_grant_q;
   assign dmem_grant      = dmem_grant_q;
   assign if_data_valid   = if_dv_q;
   assign dmem_data_valid = dmem_dv_q;
   assign bus_err         = bus_err_q;
   assign arb_busy        = arb_busy_q;
   assign mem_req         = mem_req_q;
   assign mem_we          = mem_we_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign rdata           = rdata_q;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits directly downstream of the MMU and the instruction-fetch unit; the single owner of the shared instruction/data memory port.
- Arbitrates between fetch and MMU requests and issues one transaction at a time to memory.
- Returns a one-cycle grant and a one-cycle data_valid to the winning requester.
- Adds a watchdog that terminates hung transactions with an error.

Parameters:
- ADDR_WIDTH, 32, address width (matches system ADDR_WIDTH).
- DATA_WIDTH, 32, data width (matches system DATA_WIDTH).
- TIMEOUT_CYCLES, 255, maximum cycles in ISSUE before forced error completion; must be ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- if_req_valid  input  1  fetch read request
- if_addr  input  ADDR_WIDTH  fetch address
- if_grant  output  1  one-cycle pulse: fetch request accepted
- if_data_valid  output  1  one-cycle pulse: fetch data on rdata
- dmem_req_valid  input  1  MMU request
- dmem_we  input  1  MMU write enable (1 = store)
- dmem_addr  input  ADDR_WIDTH  MMU address
- dmem_wdata  input  DATA_WIDTH  MMU store data (tristate resolved at top level)
- dmem_grant  output  1  one-cycle pulse: MMU request accepted
- dmem_data_valid  output  1  one-cycle pulse: MMU load data/store ack
- rdata  output  DATA_WIDTH  response data, shared by both requesters
- bus_err  output  1  qualifies the data_valid pulse: transaction timed out
- arb_busy  output  1  high in any state other than IDLE
- mem_req  output  1  request to memory
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion strobe

Behaviour:
- Reset: synchronous on clk. All outputs are 0, state is IDLE, last_owner=FETCH (so the MMU wins the first tie), timeout counter is 0. Reset asserted mid-transaction abandons it: no data_valid is produced and mem_req drops the next cycle.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any request is valid, select a winner.
  - Only one valid: that requester wins.
  - Both valid: the requester that is not last_owner wins (round-robin).
  - Latch the winner's addr, we and wdata. Fetch requests are latched with we=0 and wdata=0.
  - Next cycle: pulse the winner's grant and drive mem_req=1 with the latched values. Go to ISSUE.
- ISSUE:
  - Hold mem_req, mem_addr, mem_we and mem_wdata stable. Increment the counter each cycle.
  - mem_ready=1: capture mem_rdata into rdata (0 if mem_we=1), drop mem_req the next cycle, go to RESP.
  - Counter reaches TIMEOUT_CYCLES without mem_ready: drop mem_req, set rdata=0 and bus_err=1, go to RESP.
  - mem_ready takes precedence over timeout when both occur in the same cycle.
- RESP:
  - Pulse the owner's data_valid for one cycle; bus_err is valid in the same cycle.
  - Update last_owner to the owner and clear the counter. Go to IDLE.
  - rdata holds its value until the next capture.
- Request inputs are ignored outside IDLE.
- A req_valid still high in IDLE after RESP is treated as a new request.
- Minimum latency, with mem_ready in the first ISSUE cycle:
  - request seen at cycle 0;
  - grant and mem_req at cycle 1;
  - mem_ready at cycle 1;
  - data_valid at cycle 2.
- Invariants:
  - if_grant and dmem_grant are never both high.
  - if_data_valid and dmem_data_valid are never both high.
  - mem_req never spans two owners.
  - mem_ready outside ISSUE is ignored.
- Counter width is clog2(TIMEOUT_CYCLES+1). The counter saturates; it never wraps.

Test Plan:
- Single MMU load: dmem_req_valid=1, dmem_addr=0x100, dmem_we=0; memory returns 0xDEADBEEF with mem_ready 3 cycles after mem_req → dmem_grant at cycle 1, mem_addr=0x100, dmem_data_valid at cycle 5, rdata=0xDEADBEEF, bus_err=0, if_* outputs stay 0.
- Simultaneous requests out of reset: if_addr=0x0, dmem_addr=0x200 both valid, mem_ready immediate → MMU served first, then fetch, with grants 3 cycles apart; next tie after that goes to MMU.
- Store: dmem_we=1, dmem_wdata=0x12345678, dmem_addr=0x40 → mem_we=1 and mem_wdata=0x12345678 held stable until mem_ready; dmem_data_valid with rdata=0.
- Timeout: TIMEOUT_CYCLES=4, mem_ready never asserted → mem_req high for exactly 4 cycles, then dmem_data_valid=1 with bus_err=1 and rdata=0; FSM returns to IDLE.
- mem_ready coincident with timeout (mem_ready in the 4th ISSUE cycle, TIMEOUT_CYCLES=4) → normal completion, bus_err=0, rdata=mem_rdata.
- Reset in ISSUE: assert reset for 1 cycle mid-wait → all outputs 0 the next cycle, no data_valid pulse, a subsequent fetch request completes normally.
